// File: rtl/f1_start_sequencer.sv
// f1_start_sequencer
//   F1 start-light sequencer with reaction timer. A trigger in IDLE starts
//   the lamp fill (one lamp per tick, bit 0 first). Once all lamps are lit
//   they are held for a pseudo-random number of ticks taken from a
//   free-running LFSR, then go out together with a one-cycle go pulse. The
//   block then counts clk cycles until stop is pressed and reports the
//   count. A stop before go is a jump start: a sticky flag is set and the
//   sequence aborts.
//
// Parameters
//   N_LIGHTS : number of lamps (>=1)
//   LFSR_W   : delay LFSR width (>=2). Maximal-length taps for 2..16.
//   SEED     : LFSR reset value (nonzero)
//   CNT_W    : reaction counter width
//
// Ports
//   clk, rst         : clock, asynchronous active-high reset
//   tick_i           : one-cycle step enable from the prescaler
//   trigger_i        : start request, accepted only in IDLE
//   stop_i           : driver button
//   lights_o         : thermometer lamp pattern
//   go_o             : one-cycle pulse when the lamps go out
//   busy_o           : high whenever not IDLE
//   delay_o          : hold length (ticks) of the current/last start
//   react_valid_o    : one-cycle pulse qualifying react_time_o
//   react_time_o     : last measured reaction in clk cycles (saturating)
//   jump_start_o     : sticky jump-start flag, cleared by the next start
module f1_start_sequencer #(
   parameter int N_LIGHTS = 8,
   parameter int LFSR_W   = 7,
   parameter int SEED     = 1,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick_i,
   input  logic                trigger_i,
   input  logic                stop_i,
   output logic [N_LIGHTS-1:0] lights_o,
   output logic                go_o,
   output logic                busy_o,
   output logic [LFSR_W-1:0]   delay_o,
   output logic                react_valid_o,
   output logic [CNT_W-1:0]    react_time_o,
   output logic                jump_start_o
);

   // Fibonacci tap masks (bit i = x^(i+1) term) for maximal-length
   // polynomials; 7 bits gives x^7+x^6+1.
   function automatic logic [31:0] lfsr_taps(input int w);
      case (w)
         2:       return 32'h0003;
         3:       return 32'h0006;
         4:       return 32'h000C;
         5:       return 32'h0014;
         6:       return 32'h0030;
         7:       return 32'h0060;
         8:       return 32'h00B8;
         9:       return 32'h0110;
         10:      return 32'h0240;
         11:      return 32'h0500;
         12:      return 32'h0E08;
         13:      return 32'h1C80;
         14:      return 32'h3802;
         15:      return 32'h6000;
         16:      return 32'hD008;
         // Outside the table: top two bits. Still never reaches zero from a
         // nonzero seed, but the period is not guaranteed maximal.
         default: return 32'h3 << (w - 2);
      endcase
   endfunction

   localparam logic [LFSR_W-1:0]   TAPS    = LFSR_W'(lfsr_taps(LFSR_W));
   localparam logic [LFSR_W-1:0]   SEED_V  = LFSR_W'(SEED);
   localparam logic [LFSR_W-1:0]   HOLD_1  = LFSR_W'(1);
   localparam logic [N_LIGHTS-1:0] LAMP0   = N_LIGHTS'(1);
   localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, FILL, HOLD, RACE} state_e;

   state_e              state_q, state_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic [LFSR_W-1:0]   hold_q, hold_d;
   logic [LFSR_W-1:0]   delay_q, delay_d;
   logic [CNT_W-1:0]    race_q, race_d;
   logic [CNT_W-1:0]    rt_q, rt_d;
   logic [N_LIGHTS-1:0] lights_q, lights_d;
   logic                go_q, go_d;
   logic                busy_q, busy_d;
   logic                rv_q, rv_d;
   logic                js_q, js_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         lfsr_q   <= SEED_V;
         hold_q   <= '0;
         delay_q  <= '0;
         race_q   <= '0;
         rt_q     <= '0;
         lights_q <= '0;
         go_q     <= 1'b0;
         busy_q   <= 1'b0;
         rv_q     <= 1'b0;
         js_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         hold_q   <= hold_d;
         delay_q  <= delay_d;
         race_q   <= race_d;
         rt_q     <= rt_d;
         lights_q <= lights_d;
         go_q     <= go_d;
         busy_q   <= busy_d;
         rv_q     <= rv_d;
         js_q     <= js_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      lfsr_d   = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
      hold_d   = hold_q;
      delay_d  = delay_q;
      race_d   = race_q;
      rt_d     = rt_q;
      lights_d = lights_q;
      go_d     = 1'b0;
      rv_d     = 1'b0;
      js_d     = js_q;

      case (state_q)
         IDLE: begin
            if (trigger_i) begin
               state_d  = FILL;
               lights_d = '0;
               js_d     = 1'b0;
            end
         end
         FILL, HOLD: begin
            if (stop_i) begin
               // Jump start: stop wins over a coincident tick.
               state_d  = IDLE;
               lights_d = '0;
               js_d     = 1'b1;
            end else if (tick_i) begin
               if (state_q == FILL) begin
                  // The pattern itself is the lamp count: shift in a one.
                  lights_d = (lights_q << 1) | LAMP0;
                  if (&lights_d) begin
                     state_d = HOLD;
                     delay_d = lfsr_q;
                     hold_d  = lfsr_q;
                  end
               end else if (hold_q == HOLD_1) begin
                  state_d  = RACE;
                  lights_d = '0;
                  go_d     = 1'b1;
                  race_d   = '0;
               end else begin
                  hold_d = hold_q - HOLD_1;
               end
            end
         end
         RACE: begin
            if (stop_i) begin
               state_d = IDLE;
               rt_d    = race_q;
               rv_d    = 1'b1;
            end else if (race_q != '1) begin
               race_d = race_q + CNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign lights_o      = lights_q;
   assign go_o          = go_q;
   assign busy_o        = busy_q;
   assign delay_o       = delay_q;
   assign react_valid_o = rv_q;
   assign react_time_o  = rt_q;
   assign jump_start_o  = js_q;

endmodule

// File: tb/tb_f1_start_sequencer.sv
// Bench for f1_start_sequencer: two instances (CNT_W=16 and CNT_W=4, both
// N_LIGHTS=4) share one stimulus stream. A per-cycle reference model built
// from the sequencing rules predicts every output of both instances.
module tb_f1_start_sequencer;
   localparam int N    = 4;
   localparam int SEED = 1;

   logic clk = 1'b0;
   logic rst, tick, trig, stp;

   logic [N-1:0] lights_a, lights_b;
   logic         go_a, go_b, busy_a, busy_b, rv_a, rv_b, js_a, js_b;
   logic [6:0]   delay_a, delay_b;
   logic [15:0]  rt_a;
   logic [3:0]   rt_b;

   f1_start_sequencer #(.N_LIGHTS(N), .LFSR_W(7), .SEED(SEED), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .tick_i(tick), .trigger_i(trig), .stop_i(stp),
      .lights_o(lights_a), .go_o(go_a), .busy_o(busy_a), .delay_o(delay_a),
      .react_valid_o(rv_a), .react_time_o(rt_a), .jump_start_o(js_a));

   f1_start_sequencer #(.N_LIGHTS(N), .LFSR_W(7), .SEED(SEED), .CNT_W(4)) u_b (
      .clk(clk), .rst(rst), .tick_i(tick), .trigger_i(trig), .stop_i(stp),
      .lights_o(lights_b), .go_o(go_b), .busy_o(busy_b), .delay_o(delay_b),
      .react_valid_o(rv_b), .react_time_o(rt_b), .jump_start_o(js_b));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 filling, 2 holding, 3 racing.
   int         ph, k, hold, race;
   int         m_lights, m_go, m_busy, m_delay, m_rv, m_rt16, m_rt4, m_js;
   logic [6:0] m_lfsr;

   function automatic logic [6:0] lfsr_next(input logic [6:0] x);
      return {x[5:0], x[6] ^ x[5]};  // x^7 + x^6 + 1
   endfunction

   task automatic model_reset();
      ph = 0; k = 0; hold = 0; race = 0;
      m_lights = 0; m_go = 0; m_busy = 0; m_delay = 0;
      m_rv = 0; m_rt16 = 0; m_rt4 = 0; m_js = 0;
      m_lfsr = 7'(SEED);
   endtask

   task automatic model_step(input bit t_trig, input bit t_tick, input bit t_stop);
      logic [6:0] pre;
      pre = m_lfsr;
      m_lfsr = lfsr_next(m_lfsr);
      m_go = 0;
      m_rv = 0;
      case (ph)
         0: if (t_trig) begin ph = 1; k = 0; m_js = 0; m_lights = 0; end
         1, 2: begin
            if (t_stop) begin
               m_js = 1; m_lights = 0; ph = 0;
            end else if (t_tick) begin
               if (ph == 1) begin
                  k++;
                  m_lights = (1 << k) - 1;
                  if (k == N) begin ph = 2; m_delay = pre; hold = pre; end
               end else if (hold == 1) begin
                  ph = 3; m_lights = 0; m_go = 1; race = 0;
               end else begin
                  hold--;
               end
            end
         end
         default: begin
            if (t_stop) begin
               m_rt16 = (race > 65535) ? 65535 : race;
               m_rt4  = (race > 15) ? 15 : race;
               m_rv = 1;
               ph = 0;
            end else begin
               race++;
            end
         end
      endcase
      m_busy = (ph != 0) ? 1 : 0;
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".lights"}, lights_a, m_lights);
      check({tag, ".go"},     go_a,     m_go);
      check({tag, ".busy"},   busy_a,   m_busy);
      check({tag, ".delay"},  delay_a,  m_delay);
      check({tag, ".rv"},     rv_a,     m_rv);
      check({tag, ".rt16"},   rt_a,     m_rt16);
      check({tag, ".js"},     js_a,     m_js);
      check({tag, ".b.go"},   go_b,     m_go);
      check({tag, ".b.rt4"},  rt_b,     m_rt4);
      check({tag, ".b.lights"}, lights_b, m_lights);
   endtask

   task automatic cycle(input string tag, input bit t_trig, input bit t_tick, input bit t_stop);
      trig = t_trig; tick = t_tick; stp = t_stop;
      @(posedge clk);
      model_step(t_trig, t_tick, t_stop);
      cyc++;
      #1 compare_all(tag);
   endtask

   // mode 0: stop 'param' cycles after go; 1: stop in FILL at lights=0011;
   // 2: stop coincident with the final hold tick; 3: random ticks and stops.
   task automatic run(input string tag, input int mode, input int param, input bit hold_trig);
      int budget;
      bit t_tick, t_stop, started;
      budget = 3000;
      started = 0;
      do begin
         t_tick = (mode == 3) ? ($urandom_range(2) == 0) : ((cyc % 4) == 3);
         case (mode)
            0:       t_stop = (ph == 3 && race == param);
            1:       t_stop = (ph == 1 && m_lights == 3);
            2:       t_stop = (ph == 2 && t_tick && hold == 1);
            default: t_stop = ($urandom_range(39) == 0);
         endcase
         cycle(tag, !started || hold_trig, t_tick, t_stop);
         started = 1;
         budget--;
      end while (ph != 0 && budget > 0);
      if (budget == 0) check({tag, ".timeout"}, 1, 0);
   endtask

   initial begin
      rst = 1'b1; trig = 1'b0; tick = 1'b0; stp = 1'b0;
      model_reset();
      #12 compare_all("reset");
      @(negedge clk) rst = 1'b0;

      // Normal run with reaction measured 37 cycles after go.
      run("react37", 0, 37, 1'b0);
      check("react37.delay_nz", (delay_a != 0), 1);
      // Stop sampled in the go cycle.
      run("react0", 0, 0, 1'b0);
      // Saturation on the 4-bit instance.
      run("sat20", 0, 20, 1'b0);
      // Jump starts: during FILL, then on the final HOLD tick.
      run("js_fill", 1, 0, 1'b0);
      for (int i = 0; i < 3; i++) cycle("js_idle", 1'b0, 1'b0, 1'b0);
      run("js_hold", 2, 0, 1'b0);
      // Stop pulses in IDLE must change nothing.
      for (int i = 0; i < 4; i++) cycle("idle_stop", 1'b0, 1'b0, i[0]);
      // Trigger held through a whole run, then restart on the next cycle.
      run("held_trig", 0, 3, 1'b1);
      cycle("retrig", 1'b1, 1'b0, 1'b0);
      check("retrig.busy", busy_a, 1);
      run("after_retrig", 0, 5, 1'b0);

      // Async reset mid-HOLD, between edges.
      cycle("pre_rst", 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 400 && ph != 2; i++) cycle("to_hold", 1'b0, (cyc % 4) == 3, 1'b0);
      check("to_hold.reached", (ph == 2), 1);
      #3 rst = 1'b1;
      model_reset();
      #1 compare_all("async_rst");
      @(posedge clk); #1 compare_all("rst_held");
      @(negedge clk) rst = 1'b0;
      // Delay of this run checks that the LFSR restarted from SEED.
      run("post_rst", 0, 2, 1'b0);

      // Randomized runs.
      for (int r = 0; r < 25; r++) begin
         run("rand", 3, 0, 1'b0);
         for (int i = 0; i < int'($urandom_range(3)); i++)
            cycle("rand_idle", 1'b0, $urandom_range(1) == 1, $urandom_range(1) == 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
